rv32i_memory_responder: RTL

RV32I_MEMORY_RESPONDER -- requirements
Module: rv32i_memory_responder

---
 rtl/rv32i_memory_responder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rv32i_memory_responder.sv
// rv32i_memory_responder
//   Single-port memory responder for a small RV32I core: a word-addressed RAM
//   plus a 256-byte MMIO window holding an LED register, a free-running cycle
//   counter and a 4-entry byte FIFO that feeds a ready/valid sink.
//
// Parameters
//   L          RAM depth in 32-bit words (power of two)
//   MMIO_BASE  base byte address of the MMIO window (low 8 bits ignored)
//
// Ports
//   clk          clock, all state updates on rising edge
//   rst          asynchronous active-high reset
//   ena          global enable; low freezes all state
//   mem_addr     byte address from the core
//   mem_wr_data  write data from the core
//   mem_wr_ena   write strobe from the core
//   mem_rd_data  registered read data (1-cycle latency)
//   leds         LED register contents
//   tx_data      head byte of the output FIFO
//   tx_valid     FIFO non-empty
//   tx_ready     sink accepts tx_data this cycle
//   bus_error    sticky flag, set by an access outside RAM and MMIO
module rv32i_memory_responder #(
  parameter int unsigned L         = 256,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_wr_ena,
  output logic [31:0] mem_rd_data,
  output logic [31:0] leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_error
);

  localparam int AW = $clog2(L);

  localparam logic [7:0] OFF_LEDS   = 8'h00;
  localparam logic [7:0] OFF_CYCLES = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h10;
  localparam logic [7:0] OFF_STATUS = 8'h14;

  logic [31:0] ram [L];
  logic [7:0]  fifo_mem [4];

  logic [31:0] rd_q, rd_d;
  logic [31:0] leds_q;
  logic [31:0] cyc_q;
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  cnt_q, cnt_d;
  logic        ovf_q;
  logic        berr_q;

  logic          ram_hit, mmio_hit, bad_addr;
  logic [AW-1:0] ram_idx;
  logic [7:0]    mmio_off;
  logic          wr_acc, mmio_wr;
  logic          full, empty;
  logic          push, pop, push_ok, ovf_set, ovf_clr, leds_we;
  logic [31:0]   status;

  // For a power-of-two depth, "addr < 4*L" is exactly "all bits above the
  // word index are zero".
  assign ram_hit  = (mem_addr[31:AW+2] == '0);
  assign mmio_hit = !ram_hit && (mem_addr[31:8] == MMIO_BASE[31:8]);
  assign bad_addr = !ram_hit && !mmio_hit;
  assign ram_idx  = mem_addr[AW+1:2];
  assign mmio_off = mem_addr[7:0];

  assign wr_acc  = ena && mem_wr_ena;
  assign mmio_wr = wr_acc && mmio_hit;

  assign full    = (cnt_q == 3'd4);
  assign empty   = (cnt_q == 3'd0);
  assign pop     = ena && !empty && tx_ready;
  assign push    = mmio_wr && (mmio_off == OFF_TXDATA);
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign ovf_clr = mmio_wr && (mmio_off == OFF_STATUS) && mem_wr_data[5];
  assign leds_we = mmio_wr && (mmio_off == OFF_LEDS);

  assign status = {26'b0, ovf_q, full, empty, cnt_q};

  // Read mux: sampled every enabled cycle, the RAM path reads the pre-write
  // contents so a same-cycle read/write returns old data.
  always_comb begin
    rd_d = '0;
    if (ram_hit) begin
      rd_d = ram[ram_idx];
    end else if (mmio_hit) begin
      case (mmio_off)
        OFF_LEDS:   rd_d = leds_q;
        OFF_CYCLES: rd_d = cyc_q;
        OFF_STATUS: rd_d = status;
        default:    rd_d = '0;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage arrays carry no reset; their contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_acc && ram_hit) begin
      ram[ram_idx] <= mem_wr_data;
    end
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= mem_wr_data[7:0];
    end
  end

  // Control and register state. An out-of-range access only raises
  // bus_error; the counter and FIFO drain keep running as on any other
  // enabled cycle since they are not side effects of the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q     <= '0;
      leds_q   <= '0;
      cyc_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else if (ena) begin
      rd_q     <= rd_d;
      cyc_q    <= cyc_q + 32'd1;
      wr_ptr_q <= wr_ptr_q + {1'b0, push_ok};
      rd_ptr_q <= rd_ptr_q + {1'b0, pop};
      cnt_q    <= cnt_d;
      // Set wins over a same-edge clear.
      ovf_q    <= (ovf_q && !ovf_clr) || ovf_set;
      if (leds_we) begin
        leds_q <= mem_wr_data;
      end
      if (bad_addr) begin
        berr_q <= 1'b1;
      end
    end
  end

  assign mem_rd_data = rd_q;
  assign leds        = leds_q;
  assign tx_data     = fifo_mem[rd_ptr_q];
  assign tx_valid    = !empty;
  assign bus_error   = berr_q;

endmodule
